// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
//   state_t         : controller states (CLEAR, LOAD, RUN)
//   BYTES_PER_WORD  : byte lanes in a default 32-bit instruction word
//   NOP_INSTR       : instruction returned when no valid fetch is possible
//   bytes_per_word(): byte lanes for an arbitrary word width
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int BYTES_PER_WORD = 32 / 8;
  localparam int NOP_INSTR      = 0;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/instruction_memory_loadable_byte_packer.sv
// byte_packer: assembles a byte stream (most-significant byte first) into
// WIDTH-bit words.
//   clk, rst    : clock and synchronous active-high reset
//   clear       : synchronous flush of a partially assembled word
//   in_valid    : in_byte is accepted this cycle
//   in_byte     : incoming byte
//   in_last     : accepted byte is the final one; pad the word with zeros
//   word_valid  : word is complete this cycle (combinational)
//   word        : completed word, valid while word_valid is high
module byte_packer
  import imem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  output logic             word_valid,
  output logic [WIDTH-1:0] word
);

  localparam int BPW   = bytes_per_word(WIDTH);
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] merged;
  logic [CNT_W-1:0] lane;
  logic             lane_full;

  // The word is presented combinationally so the top can write it to memory
  // on the same edge that accepts its final byte. Unfilled low lanes of acc
  // are still zero, which gives the zero padding on a short final word.
  always_comb begin
    merged     = acc | (WIDTH'(in_byte) << (WIDTH - 8 - 8 * int'(lane)));
    lane_full  = (lane == CNT_W'(BPW - 1));
    word_valid = in_valid && (lane_full || in_last);
    word       = merged;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc  <= '0;
      lane <= '0;
    end else if (in_valid) begin
      if (word_valid) begin
        acc  <= '0;
        lane <= '0;
      end else begin
        acc  <= merged;
        lane <= lane + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instruction_memory_loadable.sv
// instruction_memory_loadable: runtime-loadable instruction memory with a
// combinational fetch port and a byte-serial valid/ready load port.
//   clk, rst       : clock and synchronous active-high reset
//   pc             : byte-address fetch PC
//   instr          : fetched instruction (combinational, NOP when not RUN)
//   fetch_fault    : pc misaligned or beyond the array (combinational)
//   load_start     : begin a new load (honoured only in RUN)
//   load_byte      : program byte, MSB of each word first
//   load_valid     : load_byte is valid
//   load_last      : final byte of the program
//   load_ready     : a byte is accepted this cycle (LOAD state)
//   load_done      : one-cycle pulse in the first RUN cycle after a load
//   load_overflow  : sticky, bytes arrived after the array was full
//   busy           : not in RUN
//   words_loaded   : words written by the last load
module instruction_memory_loadable
  import imem_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   pc,
  output logic [WIDTH-1:0]  instr,
  output logic              fetch_fault,
  input  logic              load_start,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_overflow,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_INSTR);

  logic [WIDTH-1:0]  mem [DEPTH];

  state_t            state, next_state;
  logic              load_pend;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   words_cnt;
  logic              ovf;
  logic              done_q;

  logic              accept;
  logic              clr_last;
  logic              wr_full;
  logic              start_load;
  logic              pk_valid;
  logic [WIDTH-1:0]  pk_word;

  logic [ADDR_W-1:0] idx;
  logic              fault_raw;

  assign accept     = (state == LOAD) && load_valid;
  assign clr_last   = (clr_ptr == ADDR_W'(DEPTH - 1));
  // wr_ptr saturates at DEPTH, so its top bit alone means "array full".
  assign wr_full    = wr_ptr[ADDR_W];
  assign start_load = (state == RUN) && load_start;

  byte_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .in_valid   (accept),
    .in_byte    (load_byte),
    .in_last    (load_last),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clr_last) next_state = load_pend ? LOAD : RUN;
      LOAD:    if (accept && load_last) next_state = RUN;
      RUN:     if (load_start) next_state = CLEAR;
      default: next_state = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_pend <= 1'b0;
      clr_ptr   <= '0;
      wr_ptr    <= '0;
      words_cnt <= '0;
      ovf       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= accept && load_last;
      case (state)
        CLEAR: begin
          // Wraps back to 0 after the last word, ready for the next sweep.
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_last) load_pend <= 1'b0;
        end
        RUN: begin
          if (load_start) begin
            load_pend <= 1'b1;
            wr_ptr    <= '0;
            words_cnt <= '0;
            ovf       <= 1'b0;
          end
        end
        LOAD: begin
          if (accept && wr_full) ovf <= 1'b1;
          if (pk_valid && !wr_full) begin
            wr_ptr    <= wr_ptr + 1'b1;
            words_cnt <= words_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents are not reset; the CLEAR sweep zeroes them instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_ptr] <= NOP_WORD;
    else if (state == LOAD && pk_valid && !wr_full)
      mem[wr_ptr[ADDR_W-1:0]] <= pk_word;
  end

  always_comb begin
    idx         = pc[ADDR_W+1:2];
    fault_raw   = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != '0);
    instr       = NOP_WORD;
    fetch_fault = 1'b0;
    if (state == RUN) begin
      fetch_fault = fault_raw;
      instr       = fault_raw ? NOP_WORD : mem[idx];
    end
  end

  assign busy          = (state != RUN);
  assign load_ready    = (state == LOAD);
  assign load_done     = done_q;
  assign load_overflow = ovf;
  assign words_loaded  = words_cnt;

endmodule
